// File: rtl/ring_freq_meter.sv
// ring_freq_meter: multi-channel ring-oscillator frequency meter.
//
// Each ring input is synchronised into clk and rising-edge detected. Edges are counted over a
// programmable gate window of G clk cycles. At the end of the window all channel counts are
// latched together and flagged with a one-cycle valid pulse. The meter runs single-shot or in
// continuous mode, where windows follow back to back. Counters saturate and report overflow.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      one-cycle measurement request, accepted only in IDLE
//   cont       continuous mode, sampled with start and again at every window end
//   gate_len   window length in clk cycles (0 behaves as 1), captured on start / re-arm
//   ring_in    asynchronous ring-oscillator outputs, one bit per channel
//   busy       high in every state except IDLE
//   valid      one-cycle pulse while count_out/ovf show a freshly latched window
//   count_out  latched counts, channel k in bits [k*CNT_W +: CNT_W]
//   ovf        per-channel saturation flag for the latched window
//
// Timing: start accepted in cycle t -> ARM at t+1, GATE over t+2..t+G+1, DONE/valid at t+G+2.
// Inputs toggling faster than f_clk/2 alias; SYNC_STAGES must be at least 2.

module ring_freq_meter #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned GATE_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    cont,
    input  logic [GATE_W-1:0]       gate_len,
    input  logic [N_CH-1:0]         ring_in,
    output logic                    busy,
    output logic                    valid,
    output logic [N_CH*CNT_W-1:0]   count_out,
    output logic [N_CH-1:0]         ovf
);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StGate,
        StDone
    } state_e;

    state_e state_q, state_d;

    // ------------------------------------------------------------------
    // Input path: synchroniser chain plus one edge register per channel
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0]                  prev_q;
    logic [N_CH-1:0]                  edge_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= ring_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

    // ------------------------------------------------------------------
    // Window configuration capture
    // ------------------------------------------------------------------
    logic [GATE_W-1:0] gate_q;
    logic [GATE_W-1:0] gate_sel;
    logic              cont_q;
    logic              capture;
    logic              rearm;

    // A zero-length window is meaningless, so it is widened to one cycle.
    assign gate_sel = (gate_len == '0) ? GATE_W'(1) : gate_len;
    assign rearm    = (state_q == StDone) && cont_q && cont;
    assign capture  = ((state_q == StIdle) && start) || rearm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_q <= GATE_W'(1);
            cont_q <= 1'b0;
        end else if (capture) begin
            gate_q <= gate_sel;
            cont_q <= cont;
        end
    end

    // ------------------------------------------------------------------
    // Gate timer: loaded with G-1 in ARM, counts down through GATE
    // ------------------------------------------------------------------
    logic [GATE_W-1:0] timer_q;
    logic              win_end;

    assign win_end = (state_q == StGate) && (timer_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else if (state_q == StArm) begin
            timer_q <= gate_q - GATE_W'(1);
        end else if ((state_q == StGate) && (timer_q != '0)) begin
            timer_q <= timer_q - GATE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StArm;
            StArm:  state_d = StGate;
            StGate: if (timer_q == '0) state_d = StDone;
            StDone: state_d = rearm ? StArm : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel saturating edge counters
    // ------------------------------------------------------------------
    logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]            acc_ovf_q, acc_ovf_d;

    always_comb begin
        cnt_d     = cnt_q;
        acc_ovf_d = acc_ovf_q;
        if (state_q == StArm) begin
            cnt_d     = '0;
            acc_ovf_d = '0;
        end else if (state_q == StGate) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (edge_pulse[k]) begin
                    // An edge arriving at all-ones is lost: hold and record overflow.
                    if (cnt_q[k] == {CNT_W{1'b1}}) begin
                        acc_ovf_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_ovf_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_ovf_q <= acc_ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    // Loaded on the edge entering DONE from the next-state counter values, so the last GATE
    // cycle's edges are included and the new results are visible during the valid cycle.
    logic [N_CH-1:0][CNT_W-1:0] count_out_q;
    logic [N_CH-1:0]            ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out_q <= '0;
            ovf_q       <= '0;
        end else if (win_end) begin
            count_out_q <= cnt_d;
            ovf_q       <= acc_ovf_d;
        end
    end

    assign count_out = count_out_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q != StIdle);
    assign valid     = (state_q == StDone);

endmodule

// File: tb/tb_ring_freq_meter.sv
module tb_ring_freq_meter;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int GW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            cont = 1'b0;
    logic [GW-1:0]   gate_len = '0;
    logic [N-1:0]    ring_in = '0;
    logic            busy;
    logic            valid;
    logic [N*CW-1:0] count_out;
    logic [N-1:0]    ovf;

    ring_freq_meter #(
        .N_CH       (N),
        .CNT_W      (CW),
        .GATE_W     (GW),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cont     (cont),
        .gate_len (gate_len),
        .ring_in  (ring_in),
        .busy     (busy),
        .valid    (valid),
        .count_out(count_out),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Ring stimulus: channel k produces one rising edge every per[k] cycles (0/1 = held low).
    int per[N];
    int ph[N];

    initial begin
        for (int k = 0; k < N; k++) begin
            per[k] = 0;
            ph[k]  = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (per[k] < 2) begin
                    ring_in[k] = 1'b0;
                    ph[k]      = 0;
                end else begin
                    ph[k]      = (ph[k] + 1 >= per[k]) ? 0 : ph[k] + 1;
                    ring_in[k] = (ph[k] < per[k] / 2);
                end
            end
        end
    end

    // Scoreboard
    typedef struct packed {
        int                 t;
        logic [N-1:0][31:0] lo;
        logic [N-1:0][31:0] hi;
        logic [N-1:0]       ov;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0][31:0] pack4(input int c0, input int c1, input int c2,
                                                 input int c3);
        logic [N-1:0][31:0] v;
        v[0] = c0;
        v[1] = c1;
        v[2] = c2;
        v[3] = c3;
        return v;
    endfunction

    function automatic void expect_win(input int t, input logic [N-1:0][31:0] lo,
                                       input logic [N-1:0][31:0] hi, input logic [N-1:0] ov);
        exp_t e;
        e.t  = t;
        e.lo = lo;
        e.hi = hi;
        e.ov = ov;
        q.push_back(e);
    endfunction

    // Monitor: every valid pulse must match the oldest expected window.
    initial begin
        exp_t e;
        int   c;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid got=1 want=0 (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    check("valid_cycle", cyc, e.t);
                    for (int k = 0; k < N; k++) begin
                        c = int'(count_out[k*CW +: CW]);
                        checks++;
                        if (c < int'(e.lo[k]) || c > int'(e.hi[k])) begin
                            failures++;
                            $display("FAIL count_ch%0d got=%0d want=[%0d..%0d] (cycle %0d)",
                                     k, c, e.lo[k], e.hi[k], cyc);
                        end
                    end
                    check("ovf", ovf, e.ov);
                    check("busy_in_done", busy, 1);
                end
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic issue(input int g, input logic c, output int t);
        @(negedge clk);
        start    = 1'b1;
        gate_len = GW'(g);
        cont     = c;
        t        = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t;

        // Reset state
        idle(3);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_count", count_out, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        idle(2);

        // Single shot, ch0 period 10, window 100
        per[0] = 10;
        idle(20);
        issue(100, 1'b0, t);
        expect_win(t + 102, pack4(9, 0, 0, 0), pack4(11, 0, 0, 0), 4'b0000);
        wait_cyc(t + 1);
        check("busy_in_arm", busy, 1);
        wait_cyc(t + 103);
        check("busy_after_done", busy, 0);
        check("drained_w1", q.size(), 0);

        // Saturation on ch1 (300 edges into an 8-bit counter), then a clean window
        per[0] = 0;
        per[1] = 2;
        idle(10);
        issue(600, 1'b0, t);
        expect_win(t + 602, pack4(0, 255, 0, 0), pack4(0, 255, 0, 0), 4'b0010);
        wait_cyc(t + 603);
        per[1] = 0;
        idle(10);
        issue(40, 1'b0, t);
        expect_win(t + 42, pack4(0, 0, 0, 0), pack4(0, 0, 0, 0), 4'b0000);
        wait_cyc(t + 43);

        // Continuous mode, periods 2/5/7/50, window 50; cont dropped during the third window
        per[0] = 2;
        per[1] = 5;
        per[2] = 7;
        per[3] = 50;
        idle(60);
        issue(50, 1'b1, t);
        for (int w = 1; w <= 3; w++) begin
            expect_win(t + 52 * w, pack4(25, 10, 6, 1), pack4(25, 10, 8, 1), 4'b0000);
        end
        wait_cyc(t + 53);
        check("rearm_busy", busy, 1);
        wait_cyc(t + 110);
        cont = 1'b0;
        wait_cyc(t + 157);
        check("cont_stop_idle", busy, 0);
        wait_cyc(t + 215);
        check("drained_cont", q.size(), 0);

        // Reset mid-window abandons it
        per[1] = 0;
        per[2] = 0;
        per[3] = 0;
        per[0] = 10;
        idle(20);
        issue(100, 1'b0, t);
        wait_cyc(t + 31);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", valid, 0);
        check("midrst_count", count_out, 0);
        check("midrst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(150);
        issue(100, 1'b0, t);
        expect_win(t + 102, pack4(9, 0, 0, 0), pack4(11, 0, 0, 0), 4'b0000);
        wait_cyc(t + 103);
        check("post_rst_idle", busy, 0);

        // Restart and gate_len change during GATE are ignored
        issue(100, 1'b0, t);
        expect_win(t + 102, pack4(9, 0, 0, 0), pack4(11, 0, 0, 0), 4'b0000);
        wait_cyc(t + 20);
        start    = 1'b1;
        gate_len = 16'd20;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(t + 103);
        check("restart_ignored_idle", busy, 0);

        // gate_len=0 behaves as a one-cycle window
        per[0] = 0;
        idle(10);
        issue(0, 1'b0, t);
        expect_win(t + 3, pack4(0, 0, 0, 0), pack4(0, 0, 0, 0), 4'b0000);
        wait_cyc(t + 4);
        check("g0_idle", busy, 0);

        // New gate_len taken only at continuous re-arm
        issue(30, 1'b1, t);
        expect_win(t + 32, pack4(0, 0, 0, 0), pack4(0, 0, 0, 0), 4'b0000);
        expect_win(t + 74, pack4(0, 0, 0, 0), pack4(0, 0, 0, 0), 4'b0000);
        wait_cyc(t + 10);
        gate_len = 16'd40;
        wait_cyc(t + 40);
        cont = 1'b0;
        wait_cyc(t + 75);
        check("rearm_len_idle", busy, 0);

        idle(20);
        check("final_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
